riscv_core_wb_arb: RTL
======================

Name: riscv_core_wb_arb

Overview:
- Writeback arbiter and load scoreboard between the execute/load units and the integer register file write port (wrt0_*).
- Merges single-cycle ALU results and in-order load responses onto the one RF write port.
- Tracks destination registers of outstanding loads and reports read-after-write hazards for the two RF read addresses to the issue stage.

Parameters:
- LD_DEPTH, 4, maximum outstanding loads; depth of the load-tag FIFO; power of two, ≥2.
- LD_AW, 2, log2(LD_DEPTH); pointer width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- alu_vld  in  1  ALU result valid.
- alu_rd  in  5  ALU destination register.
- alu_d  in  32  ALU result.
- alu_rdy  out  1  ALU result accepted this cycle.
- ld_iss  in  1  load issued this cycle; push ld_iss_rd into the tag FIFO.
- ld_iss_rd  in  5  destination of the issued load.
- ld_full  out  1  tag FIFO full; issue stage must not assert ld_iss.
- ld_vld  in  1  load response valid (responses arrive in issue order).
- ld_d  in  32  load data.
- ld_rdy  out  1  load response accepted this cycle.
- src1_RA  in  5  hazard query address 1.
- src2_RA  in  5  hazard query address 2.
- hz1  out  1  src1_RA has a pending write.
- hz2  out  1  src2_RA has a pending write.
- ovf  out  1  sticky error: ld_iss dropped while full.
- wrt0_WE  out  1  RF write enable.
- wrt0_WA  out  5  RF write address.
- wrt0_D  out  32  RF write data.

Behaviour:
- Reset, synchronous with RST=1 at a rising edge:
  - tag FIFO empty, pointers 0, count 0;
  - wrt0_WE=0, wrt0_WA=0, wrt0_D=0, ovf=0.
  - Reset mid-operation discards all outstanding tags and the staged write.
- Tag FIFO:
  - push on ld_iss; pop on accepted load response.
  - ld_full = (count==LD_DEPTH).
  - Push while full is allowed only when a pop happens in the same cycle; otherwise the push is dropped and ovf sets (cleared only by RST).
  - Simultaneous push+pop leaves count unchanged.
  - Pointers wrap modulo LD_DEPTH.
- Arbitration is fixed priority, load over ALU:
  - ld_rdy = ld_vld && (count!=0).
  - A response arriving with an empty FIFO is never accepted.
  - alu_rdy = !(ld_vld && ld_rdy).
  - Both handshakes are combinational from the inputs and current state.
- Write staging, 1-cycle latency:
  - On the edge after an accepted result: wrt0_WE=1, wrt0_WA = head tag (load) or alu_rd (ALU), wrt0_D = ld_d or alu_d.
  - With no accept, wrt0_WE=0 and WA/D hold their previous values.
  - Destination x0: the handshake completes and the tag pops, but wrt0_WE=0.
- Hazards, combinational:
  - hzN = (srcN_RA!=0) && (srcN_RA matches any valid FIFO entry, OR (wrt0_WE && wrt0_WA==srcN_RA)).
  - The staged write counts as a hazard because the RF updates only at the end of that cycle.
  - Multiple outstanding loads to the same rd keep the hazard until the last one retires.
- A ld_iss pushed this cycle affects hz from the next cycle onward.

Test Plan:
- Reset, then alu_vld=1 rd=5 d=0xDEADBEEF → alu_rdy=1; next cycle wrt0_WE=1, WA=5, D=0xDEADBEEF; following cycle WE=0.
- ld_iss rd=7, then src1_RA=7 → hz1=1. Then ld_vld d=0x1234 → ld_rdy=1; next cycle write (7, 0x1234) with hz1 still 1; one cycle later hz1=0.
- ALU (rd=3) and load (tag rd=4) both valid in the same cycle → ld_rdy=1, alu_rdy=0; writes are 4 then 3 on consecutive cycles.
- Push 4 loads (rd 1..4) → ld_full=1. A 5th ld_iss with no response → ovf=1 and count stays 4. Push+pop in the same cycle while full → rd=9 is accepted and ld_full stays 1. Tags drain in order 2,3,4,9 with pointer wrap.
- ALU rd=0 and load tag rd=0 → both handshakes complete, wrt0_WE stays 0, hz for RA=0 is always 0.
- 2 loads outstanding, assert RST one cycle → count=0, ld_full=0, hz1=hz2=0, ld_rdy=0 for a following ld_vld, ovf=0.

Source files
------------

// File: rtl/riscv_core_wb_arb.sv
// riscv_core_wb_arb
// Writeback arbiter and load scoreboard in front of the integer register
// file write port. Single-cycle ALU results and in-order load responses
// share the one RF write port, with loads taking priority. A small FIFO
// holds the destination register of every outstanding load; it supplies
// the write address when the response returns and drives the RAW hazard
// flags for the two issue-stage read addresses.
//
// Ports:
//   CLK, RST               clock; synchronous active-high reset
//   alu_vld/alu_rd/alu_d   ALU result in; alu_rdy = accepted this cycle
//   ld_iss/ld_iss_rd       load issue, pushes its destination tag
//   ld_full                tag FIFO full (issue must hold off)
//   ld_vld/ld_d            in-order load response; ld_rdy = accepted
//   src1_RA/src2_RA        hazard query addresses; hz1/hz2 results
//   ovf                    sticky: a load issue was dropped while full
//   wrt0_WE/WA/D           registered RF write port (1-cycle latency)
module riscv_core_wb_arb #(
  parameter int LD_DEPTH = 4,
  parameter int LD_AW    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        alu_vld,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_d,
  output logic        alu_rdy,
  input  logic        ld_iss,
  input  logic [4:0]  ld_iss_rd,
  output logic        ld_full,
  input  logic        ld_vld,
  input  logic [31:0] ld_d,
  output logic        ld_rdy,
  input  logic [4:0]  src1_RA,
  input  logic [4:0]  src2_RA,
  output logic        hz1,
  output logic        hz2,
  output logic        ovf,
  output logic        wrt0_WE,
  output logic [4:0]  wrt0_WA,
  output logic [31:0] wrt0_D
);

  localparam logic [LD_AW:0] DEPTH_C = (LD_AW + 1)'(LD_DEPTH);

  logic [4:0]          tag_mem_r [LD_DEPTH];
  logic [LD_AW-1:0]    wr_ptr_r;
  logic [LD_AW-1:0]    rd_ptr_r;
  logic [LD_AW:0]      count_r;

  logic                empty_s;
  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;
  logic [4:0]          head_tag_s;
  logic [LD_DEPTH-1:0] ent_vld_s;
  logic                hz1_s;
  logic                hz2_s;

  // FIFO status and handshake decisions, purely from inputs and current state
  always_comb begin
    empty_s    = (count_r == {(LD_AW + 1){1'b0}});
    full_s     = (count_r == DEPTH_C);
    head_tag_s = tag_mem_r[rd_ptr_r];
    // A response with no outstanding tag is never accepted
    pop_s      = ld_vld && !empty_s;
    // Pushing into a full FIFO only works when a pop frees the head slot
    push_s     = ld_iss && (!full_s || pop_s);
    drop_s     = ld_iss && full_s && !pop_s;
  end

  assign ld_rdy  = pop_s;
  assign alu_rdy = !(ld_vld && pop_s);
  assign ld_full = full_s;
  assign hz1     = hz1_s;
  assign hz2     = hz2_s;

  // Mark which physical slots hold live tags: offset from head below count
  always_comb begin
    ent_vld_s = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      ent_vld_s[i] = ({1'b0, LD_AW'(LD_AW'(i) - rd_ptr_r)} < count_r);
    end
  end

  // RAW hazard: any live tag matches, or the staged write is still in flight
  always_comb begin
    hz1_s = 1'b0;
    hz2_s = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      hz1_s = hz1_s | (ent_vld_s[i] && (tag_mem_r[i] == src1_RA));
      hz2_s = hz2_s | (ent_vld_s[i] && (tag_mem_r[i] == src2_RA));
    end
    // x0 is hardwired, so it can never carry a hazard
    hz1_s = (src1_RA != 5'd0) && (hz1_s || (wrt0_WE && (wrt0_WA == src1_RA)));
    hz2_s = (src2_RA != 5'd0) && (hz2_s || (wrt0_WE && (wrt0_WA == src2_RA)));
  end

  // Tag storage; contents need no reset because validity comes from count
  always_ff @(posedge CLK) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r] <= ld_iss_rd;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the staged RF write
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {LD_AW{1'b0}};
      rd_ptr_r <= {LD_AW{1'b0}};
      count_r  <= {(LD_AW + 1){1'b0}};
      ovf      <= 1'b0;
      wrt0_WE  <= 1'b0;
      wrt0_WA  <= 5'd0;
      wrt0_D   <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + LD_AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + LD_AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (LD_AW + 1)'(1);
        2'b01:   count_r <= count_r - (LD_AW + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        ovf <= 1'b1;
      end
      // Load wins the port; a write to x0 completes but never enables the RF
      if (pop_s) begin
        wrt0_WE <= (head_tag_s != 5'd0);
        wrt0_WA <= head_tag_s;
        wrt0_D  <= ld_d;
      end else if (alu_vld) begin
        wrt0_WE <= (alu_rd != 5'd0);
        wrt0_WA <= alu_rd;
        wrt0_D  <= alu_d;
      end else begin
        wrt0_WE <= 1'b0;
      end
    end
  end

endmodule
